// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and register decode for the hardware-interrupt
// controller.
//   - register offsets inside the 32-byte window
//   - ROUTE_NONE: first ROUTE field value that reaches no HWInt line
//   - ID_W: source id width; CLAIM_VLD_BIT: position of CLAIM valid flag
package intc_pkg;

  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_ENABLE  = 5'h04;
  localparam logic [4:0] OFF_MODE    = 5'h08;
  localparam logic [4:0] OFF_CLAIM   = 5'h0C;
  localparam logic [4:0] OFF_ROUTE   = 5'h10;
  localparam logic [4:0] OFF_INSERV  = 5'h14;

  localparam int         ID_W          = 3;
  localparam int         N_HWINT       = 6;
  localparam int         CLAIM_VLD_BIT = 31;
  localparam logic [2:0] ROUTE_NONE    = 3'd6;

  typedef enum logic [2:0] {
    REG_PENDING,
    REG_ENABLE,
    REG_MODE,
    REG_CLAIM,
    REG_ROUTE,
    REG_INSERV,
    REG_NONE
  } reg_sel_e;

  // Word offset (bits [1:0] already zero) -> register select.
  function automatic reg_sel_e reg_decode(input logic [4:0] off);
    reg_sel_e sel;
    case (off)
      OFF_PENDING: sel = REG_PENDING;
      OFF_ENABLE:  sel = REG_ENABLE;
      OFF_MODE:    sel = REG_MODE;
      OFF_CLAIM:   sel = REG_CLAIM;
      OFF_ROUTE:   sel = REG_ROUTE;
      OFF_INSERV:  sel = REG_INSERV;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-index-wins priority encoder, purely combinational.
// Ports:
//   req   [N_SRC-1:0]  eligible sources
//   valid              at least one request
//   id    [ID_W-1:0]   index of the lowest set request (0 when none)
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_hwint_ctrl.sv
// intc_hwint_ctrl: collects N_SRC device interrupt lines, latches them per
// source, masks and routes them onto the six CP0 HWInt inputs. Software
// claims the winner through CLAIM and re-arms it by writing COMPLETE.
//
// Build option: define INTC_EDGE_EN to build the MODE register, edge
// latching and the irq_prev flops. Without it every source is level mode.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   irq_in [N_SRC-1:0]  device interrupt lines (synchronous, active-high)
//   addr, re, we, wdata memory-mapped bus; addr[1:0] ignored
//   rdata               combinational read data, 0 outside the window
//   hwint  [5:0]        registered HWInt lines to CP0
module intc_hwint_ctrl
  import intc_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [31:0]      addr,
  input  logic             re,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [5:0]       hwint
);

  logic [N_SRC-1:0]   irq_q, irq_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   enable_q, enable_d;
  logic [N_SRC-1:0]   in_service_q, in_service_d;
  logic [3*N_SRC-1:0] route_q, route_d;
  logic [5:0]         hwint_q, hwint_d;
  logic [N_SRC-1:0]   mode_vec;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic [31:0] addr_w, off_w;
  logic        hit;
  reg_sel_e    reg_sel;
  logic        wr_en;

  assign addr_w  = {addr[31:2], 2'b00};
  assign off_w   = addr_w - BASE_ADDR;
  // Unsigned wrap makes addresses below the base land far outside.
  assign hit     = (off_w < 32'd32);
  assign reg_sel = hit ? reg_decode(off_w[4:0]) : REG_NONE;
  assign wr_en   = we & hit;

  // ---------------------------------------------------------------------
  // Eligibility and claim winner
  // ---------------------------------------------------------------------
  logic [N_SRC-1:0] eligible;
  logic             win_vld;
  logic [ID_W-1:0]  win_id;

  assign eligible = pending_q & enable_q & ~in_service_q;

  intc_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (eligible),
    .valid (win_vld),
    .id    (win_id)
  );

  // A simultaneous write suppresses the read side effect.
  logic claim_rd;
  assign claim_rd = re & ~we & (reg_sel == REG_CLAIM) & win_vld;

  logic [ID_W-1:0]  cmpl_id;
  logic             cmpl_wr;
  logic [N_SRC-1:0] claim_vec, cmpl_vec;

  assign cmpl_id = wdata[ID_W-1:0];
  assign cmpl_wr = wr_en & (reg_sel == REG_CLAIM) & (32'(cmpl_id) < 32'(N_SRC));

  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_vec[i] = claim_rd & (win_id == ID_W'(i));
      cmpl_vec[i]  = cmpl_wr & (cmpl_id == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Pending latch
  // ---------------------------------------------------------------------
`ifdef INTC_EDGE_EN
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] irq_prev_q;
  logic [N_SRC-1:0] edge_set;

  assign mode_vec = mode_q;
  assign edge_set = irq_q & ~irq_prev_q;

  // Edge sources hold until claimed; a new edge in the claim cycle wins
  // over the clear so that event is not lost.
  always_comb begin
    pending_d = (mode_q & ((pending_q & ~claim_vec) | edge_set))
              | (~mode_q & irq_q);
    mode_d    = mode_q;
    if (wr_en && reg_sel == REG_MODE) mode_d = wdata[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      mode_q     <= mode_d;
      irq_prev_q <= irq_q;
    end
  end
`else
  assign mode_vec = '0;

  always_comb begin
    pending_d = irq_q;
  end
`endif

  // ---------------------------------------------------------------------
  // Register writes, service tracking, routing
  // ---------------------------------------------------------------------
  always_comb begin
    irq_d        = irq_in;
    enable_d     = enable_q;
    route_d      = route_q;
    in_service_d = (in_service_q | claim_vec) & ~cmpl_vec;
    if (wr_en && reg_sel == REG_ENABLE) enable_d = wdata[N_SRC-1:0];
    if (wr_en && reg_sel == REG_ROUTE)  route_d  = wdata[3*N_SRC-1:0];
  end

  always_comb begin
    logic [2:0] r;
    hwint_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      r = route_q[3*i +: 3];
      for (int k = 0; k < N_HWINT; k++) begin
        if (eligible[i] && (r < ROUTE_NONE) && (r == 3'(k))) hwint_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q        <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      in_service_q <= '0;
      route_q      <= '0;
      hwint_q      <= '0;
    end else begin
      irq_q        <= irq_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      in_service_q <= in_service_d;
      route_q      <= route_d;
      hwint_q      <= hwint_d;
    end
  end

  assign hwint = hwint_q;

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PENDING: rdata = 32'(pending_q);
      REG_ENABLE:  rdata = 32'(enable_q);
      REG_MODE:    rdata = 32'(mode_vec);
      REG_CLAIM: begin
        rdata[CLAIM_VLD_BIT] = win_vld;
        rdata[ID_W-1:0]      = win_vld ? win_id : '0;
      end
      REG_ROUTE:   rdata = 32'(route_q);
      REG_INSERV:  rdata = 32'(in_service_q);
      default:     rdata = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:3*N_SRC]};

endmodule

// File: doc/intc_hwint_ctrl.md
# intc_hwint_ctrl

Programmable interrupt controller that collects up to eight device interrupt lines, latches them per source, masks and routes them onto the six CP0 hardware-interrupt inputs (HWInt[5:0]). Sits on the memory-mapped device bus beside the timers. It is the only driver of CP0's HWInt port. Software reads a CLAIM register to identify and acknowledge the winning source and writes COMPLETE before eret to re-arm it.

## Interface
- N_SRC, 8: number of device sources, 1..8; unused upper bits read 0.
- BASE_ADDR, 32'h0000_7F40: byte address of register window, 32 bytes, word aligned.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- irq_in  in  N_SRC  device interrupt lines, synchronous to clk, active-high.
- addr  in  32  bus byte address; bits [1:0] ignored.
- re  in  1  read strobe (needed for CLAIM side effect).
- we  in  1  write strobe; when we and re are both high, the write wins and there is no read side effect.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr; 0 when addr is outside the window.
- hwint  out  6  registered, to CP0 HWInt.

## Operation
Registers, offset from BASE_ADDR:
- 0x00 PENDING, RO: pending[N_SRC-1:0].
- 0x04 ENABLE, RW: per-source enable.
- 0x08 MODE, RW: 1 = edge, 0 = level (see Configuration).
- 0x0C CLAIM/COMPLETE:
  - Read returns {valid in bit31, 28'b0, id[2:0]}.
  - Write takes wdata[2:0] as COMPLETE id.
- 0x10 ROUTE, RW: 3 bits per source, packed; source i uses bits [3i+2:3i]. Values 0..5 select a HWInt line; 6 and 7 route nowhere.
- 0x14 INSERV, RO: in_service vector.

Reset values: all registers, irq_q, pending, in_service and hwint are 0.

Per-source state updates:
- irq_q <= irq_in.
- Level source: pending <= irq_q.
- Edge source: pending <= pending | (irq_q & ~irq_prev). It is cleared only by a claim of that source.

Eligibility and routing:
- eligible[i] = pending[i] & enable[i] & ~in_service[i].
- hwint[k] <= OR over i of (eligible[i] & route[i]==k).

CLAIM read (re, no we, addr hits CLAIM):
- Winner is the lowest-index eligible source.
- If no source is eligible: return valid=0, id=0, and nothing changes.
- Otherwise, at the clock edge: in_service[id] <= 1, and for an edge source pending[id] <= 0.

COMPLETE write: in_service[id] <= 0. Ignored if id >= N_SRC or that source is not in service.

Writes to PENDING and INSERV are ignored. Unused bits read 0.

## Timing
- irq_in rising at edge k: irq_q at k+1, pending at k+2, hwint at k+3. Latency is 3 cycles, in both modes.
- Claim takes effect at the edge that ends the read cycle. hwint drops one edge later if no other eligible source shares the line.
- Edge event arriving in the same cycle as that source's claim: the set wins. pending stays 1, and the source fires again after COMPLETE.
- COMPLETE and a new edge in the same cycle: both apply.
- ENABLE or ROUTE change affects hwint on the following edge.
- Reset asserted mid-service clears in_service and pending. Events present during reset are lost; edge detection rearms from irq_prev = 0.

## Configuration
- INTC_EDGE_EN defined: MODE register exists, and edge latching plus irq_prev flops are built.
- INTC_EDGE_EN undefined: every source is level mode; MODE reads 0 and writes are ignored; no irq_prev flops.

## Structure
- Package intc_pkg holds:
  - register offsets (OFF_PENDING .. OFF_INSERV);
  - ROUTE_NONE = 3'd6;
  - the ID width of 3;
  - the CLAIM valid bit position, 31.
- One sub-module, intc_prio_enc: lowest-index priority encoder over eligible[N_SRC-1:0], giving valid and id. It is purely combinational.

## Test plan
- Level path: N_SRC=8, ENABLE=0x01, ROUTE source0=2, irq_in[0] high at cycle 0 -> hwint=6'b000100 at cycle 3. CLAIM reads 0x8000_0000, after which hwint=0. COMPLETE 0 with line still high -> hwint reasserts 2 cycles later.
- Edge path (INTC_EDGE_EN): MODE=0x08, ENABLE=0x08, route3=0, 1-cycle pulse on irq_in[3] -> PENDING=0x08 and hwint[0]=1. CLAIM returns 0x8000_0003 and PENDING=0.
- Priority: sources 1 and 5 pending, both routed to line 4 -> first CLAIM id=1, second CLAIM id=5. hwint[4] stays high until both are claimed.
- Edge pulse on source 2 in the same cycle as its CLAIM -> PENDING bit2 stays 1, INSERV=0x04. After COMPLETE 2, hwint reasserts.
- Empty claim and bogus complete: CLAIM with nothing eligible -> 0x0000_0000 and no state change. COMPLETE 7 with N_SRC=4 is ignored. Simultaneous re/we on CLAIM writes only.
- Reset with INSERV=0x03 and PENDING=0x0C -> all registers and hwint read 0 the next cycle.
